ram_access_unit: RTL and testbench

- Initiator-side controller for the team's synchronous dual-port RAM, which has 1-cycle registered read latency and a write strobe sampled on the clock edge.
- Accepts single-word write requests and burst read requests from the CPU or a DMA client over a valid/ready request channel.
- Drives the RAM read/write ports from registered outputs, absorbs read latency, and returns read data on a valid/ready response stream with backpressure.

---
 rtl/ram_access_pkg.sv | 15 +
 rtl/ram_access_unit_if.sv | 39 +++
 rtl/ram_resp_fifo.sv | 47 ++++
 rtl/ram_access_unit.sv | 129 ++++++++++++
 tb/tb_ram_access_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_pkg.sv
// Shared state encoding and default widths for the RAM access unit.
package ram_access_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_access_unit_if.sv
// Request, response and RAM-port bundle of the RAM access unit.
interface ram_access_unit_if
    import ram_access_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_last;

    logic [ADDR_WIDTH-1:0] ram_read_address;
    logic [ADDR_WIDTH-1:0] ram_write_address;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_in;
    logic [DATA_WIDTH-1:0] ram_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata, resp_ready, ram_out,
        output req_ready, resp_valid, resp_data, resp_last,
               ram_read_address, ram_write_address, ram_write, ram_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata, resp_ready, ram_out,
        input  req_ready, resp_valid, resp_data, resp_last,
               ram_read_address, ram_write_address, ram_write, ram_in
    );

endinterface

// File: rtl/ram_resp_fifo.sv
// Response buffer (data + last); head visible combinationally, count feeds the issue credits.
// Latency: a push is visible at the head the next cycle; backpressure: pop only when non-empty.
module ram_resp_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != FULL_CNT) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (!do_push && do_pop) count <= count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/ram_access_unit.sv
// Write/burst-read initiator for a 1-cycle registered-read RAM; write hits the RAM port 1 cycle after accept.
// First read word 3 cycles after accept; resp_ready stalls the FIFO and read issue is credit-limited.
module ram_access_unit
    import ram_access_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    ram_access_unit_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W+1)'(FIFO_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]  remaining;
    // p1: address on the RAM port this cycle; p2: its data is on ram_out this cycle
    logic                  p1_vld;
    logic                  p1_last;
    logic                  p2_vld;
    logic                  p2_last;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CNT_W:0]        credit_use;

    logic                  accept;
    logic                  accept_wr;
    logic                  accept_rd;
    logic                  issue;

    assign bus.req_ready = (state == ST_IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign accept_wr     = accept && bus.req_write;
    assign accept_rd     = accept && !bus.req_write;

    assign credit_use = {1'b0, fifo_count} + (CNT_W+1)'(p1_vld) + (CNT_W+1)'(p2_vld);
    assign issue      = (state == ST_READ) && (remaining != '0) && (credit_use < CREDIT_LIM);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept_rd) state_nxt = ST_READ;
            end
            ST_READ: begin
                if ((remaining == '0) || (issue && (remaining == LEN_WIDTH'(1))))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!p1_vld && !p2_vld &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop)))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt              <= '0;
            remaining             <= '0;
            p1_vld                <= 1'b0;
            p1_last               <= 1'b0;
            p2_vld                <= 1'b0;
            p2_last               <= 1'b0;
            bus.ram_read_address  <= '0;
            bus.ram_write_address <= '0;
            bus.ram_write         <= 1'b0;
            bus.ram_in            <= '0;
        end else begin
            bus.ram_write <= accept_wr;
            if (accept_wr) begin
                bus.ram_write_address <= bus.req_addr;
                bus.ram_in            <= bus.req_wdata;
            end

            p2_vld  <= p1_vld;
            p2_last <= p1_last;
            p1_vld  <= 1'b0;
            // Acceptance itself issues the first address of the burst
            if (accept_rd) begin
                bus.ram_read_address <= bus.req_addr;
                addr_cnt             <= bus.req_addr + ADDR_WIDTH'(1);
                remaining            <= bus.req_len;
                p1_vld               <= 1'b1;
                p1_last              <= (bus.req_len == '0);
            end else if (issue) begin
                bus.ram_read_address <= addr_cnt;
                addr_cnt             <= addr_cnt + ADDR_WIDTH'(1);
                remaining            <= remaining - LEN_WIDTH'(1);
                p1_vld               <= 1'b1;
                p1_last              <= (remaining == LEN_WIDTH'(1));
            end
        end
    end

    assign bus.resp_valid = !fifo_empty && !reset;
    assign fifo_pop       = bus.resp_valid && bus.resp_ready;
    assign bus.resp_data  = fifo_head[DATA_WIDTH-1:0];
    assign bus.resp_last  = fifo_head[DATA_WIDTH];

    ram_resp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (p2_vld),
        .push_dat ({p2_last, bus.ram_out}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: RAM model, shadow-memory response model checked every cycle, directed scenarios.
module tb_ram_access_unit;

    typedef struct {
        logic [15:0] dat;
        logic        last;
    } resp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   pop_cnt = 0;

    resp_t       exp_q[$];
    logic [15:0] shadow [256];
    logic [15:0] ram [256];
    logic        wr_pend;
    logic        stall_prev;
    logic [7:0]  wr_addr;
    logic [15:0] wr_dat;
    logic [15:0] prev_dat;
    logic        prev_last;

    ram_access_unit_if bus ();

    ram_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        bus.ram_out = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_write) ram[bus.ram_write_address] <= bus.ram_in;
            bus.ram_out <= ram[bus.ram_read_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a read enqueues its whole burst from the shadow memory at acceptance time
    initial begin
        resp_t e;
        for (int i = 0; i < 256; i++) shadow[i] = 16'(i);
        wr_pend = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                wr_pend    = 1'b0;
                stall_prev = 1'b0;
                chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
                chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
            end else begin
                chk("req_ready", 32'(bus.req_ready), 32'(exp_q.size() == 0));
                chk("ram_write", 32'(bus.ram_write), 32'(wr_pend));
                if (wr_pend) begin
                    chk("ram_write_address", 32'(bus.ram_write_address), 32'(wr_addr));
                    chk("ram_in", 32'(bus.ram_in), 32'(wr_dat));
                end
                chk("fifo_count_bound", 32'(dut.u_fifo.count <= 3'd4), 32'(1));
                if (stall_prev) begin
                    chk("stall_valid", 32'(bus.resp_valid), 32'(1));
                    chk("stall_data", 32'(bus.resp_data), 32'(prev_dat));
                    chk("stall_last", 32'(bus.resp_last), 32'(prev_last));
                end
                if (exp_q.size() == 0) begin
                    chk("idle_resp_valid", 32'(bus.resp_valid), 32'(0));
                end else if (bus.resp_valid && bus.resp_ready) begin
                    e = exp_q.pop_front();
                    chk("resp_data", 32'(bus.resp_data), 32'(e.dat));
                    chk("resp_last", 32'(bus.resp_last), 32'(e.last));
                    pop_cnt++;
                end
                stall_prev = bus.resp_valid && !bus.resp_ready;
                prev_dat   = bus.resp_data;
                prev_last  = bus.resp_last;
                wr_pend    = 1'b0;
                if (bus.req_valid && bus.req_ready) begin
                    if (bus.req_write) begin
                        shadow[bus.req_addr] = bus.req_wdata;
                        wr_pend = 1'b1;
                        wr_addr = bus.req_addr;
                        wr_dat  = bus.req_wdata;
                    end else begin
                        for (int i = 0; i <= int'(bus.req_len); i++) begin
                            e.dat  = shadow[8'(int'(bus.req_addr) + i)];
                            e.last = (i == int'(bus.req_len));
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic send(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                        input logic [15:0] wdat, output int acc);
        bit done = 1'b0;
        acc = -1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_wdata = wdat;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc  = cyc;
                done = 1'b1;
            end
            sync();
        end
        bus.req_valid = 1'b0;
        if (!done) chk("req_accept_timeout", 32'(done), 32'(1));
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (exp_q.size() == 0 && bus.req_ready) done = 1'b1;
            else sync();
        end
        if (!done) chk("drain_timeout", 32'(done), 32'(1));
    endtask

    initial begin
        int m;
        int n;
        int w;
        int p0;
        logic [15:0] t3_exp [4];
        logic [3:0]  pat;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) sync();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'(1));
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("reset_ram_write", 32'(bus.ram_write), 32'(0));
        chk("reset_ram_read_address", 32'(bus.ram_read_address), 32'(0));
        chk("reset_ram_write_address", 32'(bus.ram_write_address), 32'(0));
        chk("reset_ram_in", 32'(bus.ram_in), 32'(0));
        chk("reset_resp_last", 32'(bus.resp_last), 32'(0));
        sync();

        // Single write: RAM port active for exactly one cycle
        send(1'b1, 8'h05, 4'd0, 16'h1234, n);
        at_cycle(n + 1);
        chk("t1_ram_write", 32'(bus.ram_write), 32'(1));
        chk("t1_ram_write_address", 32'(bus.ram_write_address), 32'h05);
        chk("t1_ram_in", 32'(bus.ram_in), 32'h1234);
        chk("t1_req_ready", 32'(bus.req_ready), 32'(1));
        at_cycle(n + 2);
        chk("t1_ram_write_off", 32'(bus.ram_write), 32'(0));
        sync();

        // Read-after-write on the following cycle
        send(1'b1, 8'h10, 4'd0, 16'hBEEF, n);
        send(1'b0, 8'h10, 4'd0, 16'h0000, m);
        chk("t2_read_accept_cycle", 32'(m), 32'(n + 1));
        at_cycle(m + 1);
        chk("t2_valid_m1", 32'(bus.resp_valid), 32'(0));
        at_cycle(m + 2);
        chk("t2_valid_m2", 32'(bus.resp_valid), 32'(0));
        at_cycle(m + 3);
        chk("t2_valid_m3", 32'(bus.resp_valid), 32'(1));
        chk("t2_data", 32'(bus.resp_data), 32'hBEEF);
        chk("t2_last", 32'(bus.resp_last), 32'(1));
        sync();
        wait_drain();

        // Wrapping burst at full rate
        t3_exp[0] = 16'h00FE;
        t3_exp[1] = 16'h00FF;
        t3_exp[2] = 16'h0000;
        t3_exp[3] = 16'h0001;
        send(1'b0, 8'hFE, 4'd3, 16'h0000, m);
        at_cycle(m + 2);
        chk("t3_valid_m2", 32'(bus.resp_valid), 32'(0));
        for (int i = 0; i < 4; i++) begin
            at_cycle(m + 3 + i);
            chk("t3_valid", 32'(bus.resp_valid), 32'(1));
            chk("t3_data", 32'(bus.resp_data), 32'(t3_exp[i]));
            chk("t3_last", 32'(bus.resp_last), 32'(i == 3));
        end
        at_cycle(m + 7);
        chk("t3_req_ready_after", 32'(bus.req_ready), 32'(1));
        chk("t3_valid_after", 32'(bus.resp_valid), 32'(0));
        sync();

        // 16-word burst under a stalling consumer
        pat = 4'b1001;
        p0  = pop_cnt;
        send(1'b0, 8'h20, 4'd15, 16'h0000, m);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            bus.resp_ready = pat[k % 4];
            sync();
        end
        bus.resp_ready = 1'b1;
        chk("t4_pops", 32'(pop_cnt - p0), 32'd16);
        chk("t4_drained", 32'(exp_q.size()), 32'(0));
        wait_drain();

        // Reset mid-burst abandons it
        send(1'b0, 8'h40, 4'd7, 16'h0000, m);
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        at_cycle(m + 3);
        chk("t5_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("t5_ram_write", 32'(bus.ram_write), 32'(0));
        chk("t5_req_ready", 32'(bus.req_ready), 32'(1));
        sync();
        send(1'b0, 8'h03, 4'd0, 16'h0000, m);
        at_cycle(m + 3);
        chk("t5_valid", 32'(bus.resp_valid), 32'(1));
        chk("t5_data", 32'(bus.resp_data), 32'h0003);
        chk("t5_last", 32'(bus.resp_last), 32'(1));
        sync();
        wait_drain();

        // Request held during READ/DRAIN is taken in the first IDLE cycle
        send(1'b0, 8'h50, 4'd2, 16'h0000, m);
        send(1'b1, 8'h60, 4'd0, 16'hAAAA, w);
        chk("t6_accept_cycle", 32'(w), 32'(m + 6));
        at_cycle(w + 1);
        chk("t6_ram_write", 32'(bus.ram_write), 32'(1));
        chk("t6_ram_write_address", 32'(bus.ram_write_address), 32'h60);
        chk("t6_ram_in", 32'(bus.ram_in), 32'hAAAA);
        sync();
        send(1'b0, 8'h60, 4'd0, 16'h0000, m);
        at_cycle(m + 3);
        chk("t6_readback", 32'(bus.resp_data), 32'hAAAA);
        sync();
        wait_drain();

        repeat (3) sync();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
